local_search_move_selector: RTL and testbench

//  Upstream driver for the gain-computation stage. On in_start it snapshots the current assignment and builds a

---
 rtl/lsms_pkg.sv | 35 +++
 rtl/candidate_move_generator.sv | 74 +++++++
 rtl/local_search_move_selector.sv | 247 ++++++++++++++++++++++++
 tb/tb_local_search_move_selector.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsms_pkg.sv
// -----------------------------------------------------------------------------
// lsms_pkg
// Shared definitions for the local-search move selector.
//   - Default problem dimensions (integer/boolean variable counts, value width,
//     clause-index width, gain latency) and the widths derived from them.
//   - Candidate index layout: 0 = no move, then +1/-1 pairs per integer
//     variable, then one flip per boolean variable.
//   - FSM state encoding.
// -----------------------------------------------------------------------------
package lsms_pkg;

  localparam int NI_IDX_W         = 1;                // log2 of integer variable count
  localparam int NB_IDX_W         = 1;                // log2 of boolean variable count
  localparam int W                = 4;                // integer value width (two's complement)
  localparam int CI_W             = 2;                // log2 of clause count
  localparam int GAIN_LATENCY_DEF = 2;                // gain stage latency in cycles

  localparam int NI     = 1 << NI_IDX_W;
  localparam int NB     = 1 << NB_IDX_W;
  localparam int NC     = 1 + 2 * NI + NB;            // total candidate count
  localparam int IDX_W  = $clog2(NC);
  localparam int GAIN_W = CI_W + 1;

  // Candidate index ranges for the default dimensions
  localparam int CAND_NO_MOVE   = 0;
  localparam int CAND_INT_BASE  = 1;                  // +1 on var k at BASE+2k, -1 at BASE+2k+1
  localparam int CAND_BOOL_BASE = CAND_INT_BASE + 2 * NI;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } lsms_state_e;

endpackage : lsms_pkg

// File: rtl/candidate_move_generator.sv
// -----------------------------------------------------------------------------
// candidate_move_generator
// Purely combinational: maps a snapshot assignment and a candidate index to
// the assignment after that move, plus a validity flag.
//   i_int   NI*W  snapshot integer values, var k at [k*W +: W]
//   i_bool  NB    snapshot boolean values
//   i_idx   IDX_W candidate index
//   o_int   NI*W  integer values after the move
//   o_bool  NB    boolean values after the move
//   o_valid 1     move exists and does not overflow the integer range
// An increment of the maximum value or a decrement of the minimum value is
// marked invalid and the assignment is left untouched, so no wrapped value is
// ever produced.
// -----------------------------------------------------------------------------
module candidate_move_generator
  import lsms_pkg::*;
#(
  parameter int P_NI    = NI,
  parameter int P_NB    = NB,
  parameter int P_W     = W,
  parameter int P_IDX_W = IDX_W
) (
  input  logic [P_NI*P_W-1:0] i_int,
  input  logic [P_NB-1:0]     i_bool,
  input  logic [P_IDX_W-1:0]  i_idx,
  output logic [P_NI*P_W-1:0] o_int,
  output logic [P_NB-1:0]     o_bool,
  output logic                o_valid
);

  localparam int LP_NC        = 1 + 2 * P_NI + P_NB;
  localparam int LP_INT_BASE  = 1;
  localparam int LP_BOOL_BASE = LP_INT_BASE + 2 * P_NI;

  localparam logic [P_W-1:0] LP_MAX_V = {1'b0, {(P_W-1){1'b1}}};
  localparam logic [P_W-1:0] LP_MIN_V = {1'b1, {(P_W-1){1'b0}}};
  localparam logic [P_W-1:0] LP_ONE   = {{(P_W-1){1'b0}}, 1'b1};

  logic [31:0] w_idx;

  assign w_idx = 32'(i_idx);

  // Apply the move selected by i_idx to the snapshot and judge its validity
  always_comb begin
    o_int   = i_int;
    o_bool  = i_bool;
    o_valid = (w_idx < 32'(LP_NC));
    for (int k = 0; k < P_NI; k++) begin
      if (w_idx == 32'(LP_INT_BASE + 2 * k)) begin
        if (i_int[k*P_W +: P_W] == LP_MAX_V) begin
          o_valid = 1'b0;
        end else begin
          o_int[k*P_W +: P_W] = i_int[k*P_W +: P_W] + LP_ONE;
        end
      end else if (w_idx == 32'(LP_INT_BASE + 2 * k + 1)) begin
        if (i_int[k*P_W +: P_W] == LP_MIN_V) begin
          o_valid = 1'b0;
        end else begin
          o_int[k*P_W +: P_W] = i_int[k*P_W +: P_W] - LP_ONE;
        end
      end else begin
        o_int[k*P_W +: P_W] = i_int[k*P_W +: P_W];
      end
    end
    for (int b = 0; b < P_NB; b++) begin
      if (w_idx == 32'(LP_BOOL_BASE + b)) begin
        o_bool[b] = ~i_bool[b];
      end else begin
        o_bool[b] = i_bool[b];
      end
    end
  end

endmodule : candidate_move_generator

// File: rtl/local_search_move_selector.sv
// -----------------------------------------------------------------------------
// local_search_move_selector
// Drives a gain-computation stage with every single-step move around a
// snapshot assignment and reports the move with the highest gain.
// Ports:
//   in_clk / in_reset                  clock, asynchronous active-low reset
//   in_start                           start a search (sampled in IDLE only)
//   in_integer_current_assignment      NI*W snapshot integer values
//   in_boolean_current_assignment      NB   snapshot boolean values
//   in_number_of_satisfied_clauses     CI+1 gain returned by the gain stage
//   out_integer_assignment_after_move  NI*W candidate presented to the gain stage
//   out_boolean_assignment_after_move  NB   candidate presented to the gain stage
//   out_gain_enable                    1    candidate valid for the gain stage
//   out_best_integer_assignment        NI*W winning integer assignment
//   out_best_boolean_assignment        NB   winning boolean assignment
//   out_best_gain                      CI+1 gain of the winner
//   out_best_move_index                IDX  index of the winner
//   out_busy                           1    search in progress
//   out_done                           1    one-cycle completion pulse
// All outputs are registers. Candidate outputs are loaded from the next-state
// values so that the presented candidate always lines up with r_state/r_idx.
// -----------------------------------------------------------------------------
module local_search_move_selector
  import lsms_pkg::*;
#(
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = NI_IDX_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = NB_IDX_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE       = W,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = CI_W,
  parameter int GAIN_LATENCY                                = GAIN_LATENCY_DEF,
  localparam int LP_NI    = 1 << MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
  localparam int LP_NB    = 1 << MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
  localparam int LP_W     = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE,
  localparam int LP_GW    = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX + 1,
  localparam int LP_NC    = 1 + 2 * LP_NI + LP_NB,
  localparam int LP_IDX_W = $clog2(LP_NC)
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic                     in_start,
  input  logic [LP_NI*LP_W-1:0]    in_integer_current_assignment,
  input  logic [LP_NB-1:0]         in_boolean_current_assignment,
  input  logic [LP_GW-1:0]         in_number_of_satisfied_clauses,
  output logic [LP_NI*LP_W-1:0]    out_integer_assignment_after_move,
  output logic [LP_NB-1:0]         out_boolean_assignment_after_move,
  output logic                     out_gain_enable,
  output logic [LP_NI*LP_W-1:0]    out_best_integer_assignment,
  output logic [LP_NB-1:0]         out_best_boolean_assignment,
  output logic [LP_GW-1:0]         out_best_gain,
  output logic [LP_IDX_W-1:0]      out_best_move_index,
  output logic                     out_busy,
  output logic                     out_done
);

  localparam int LP_CNT_W = (GAIN_LATENCY > 1) ? $clog2(GAIN_LATENCY) : 1;

  localparam logic [LP_CNT_W-1:0] LP_LAST_CNT  = LP_CNT_W'(GAIN_LATENCY - 1);
  localparam logic [LP_CNT_W-1:0] LP_CNT_ONE   = LP_CNT_W'(1);
  localparam logic [LP_IDX_W-1:0] LP_LAST_IDX  = LP_IDX_W'(LP_NC - 1);
  localparam logic [LP_IDX_W-1:0] LP_IDX_ONE   = LP_IDX_W'(1);
  // Every clause satisfied: no later candidate can beat this
  localparam logic [LP_GW-1:0]    LP_GAIN_FULL = {1'b1, {(LP_GW-1){1'b0}}};

  lsms_state_e               r_state;
  lsms_state_e               w_state_nxt;
  logic [LP_IDX_W-1:0]       r_idx;
  logic [LP_IDX_W-1:0]       w_idx_nxt;
  logic [LP_CNT_W-1:0]       r_cnt;
  logic [LP_CNT_W-1:0]       w_cnt_nxt;
  logic [LP_NI*LP_W-1:0]     r_snap_int;
  logic [LP_NI*LP_W-1:0]     w_snap_int_nxt;
  logic [LP_NB-1:0]          r_snap_bool;
  logic [LP_NB-1:0]          w_snap_bool_nxt;
  logic                      w_sample;
  logic                      w_update;
  logic                      w_start;

  logic [LP_NI*LP_W-1:0]     w_cand_int;
  logic [LP_NB-1:0]          w_cand_bool;
  logic                      w_cand_valid;

  logic [LP_NI*LP_W-1:0]     r_after_int;
  logic [LP_NB-1:0]          r_after_bool;
  logic                      r_gain_en;
  logic [LP_NI*LP_W-1:0]     r_best_int;
  logic [LP_NB-1:0]          r_best_bool;
  logic [LP_GW-1:0]          r_best_gain;
  logic [LP_IDX_W-1:0]       r_best_idx;
  logic                      r_busy;
  logic                      r_done;

  // The generator sees next-state values so the registered candidate matches the state it is shown in
  candidate_move_generator #(
    .P_NI    (LP_NI),
    .P_NB    (LP_NB),
    .P_W     (LP_W),
    .P_IDX_W (LP_IDX_W)
  ) u_candidate_move_generator (
    .i_int   (w_snap_int_nxt),
    .i_bool  (w_snap_bool_nxt),
    .i_idx   (w_idx_nxt),
    .o_int   (w_cand_int),
    .o_bool  (w_cand_bool),
    .o_valid (w_cand_valid)
  );

  assign w_start = (r_state == ST_IDLE) && in_start;

  // Next-state logic: candidate sequencing, latency counting, skip and early exit
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_snap_int_nxt  = r_snap_int;
    w_snap_bool_nxt = r_snap_bool;
    w_sample        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_start) begin
          w_state_nxt     = ST_EVAL;
          w_idx_nxt       = '0;
          w_cnt_nxt       = '0;
          w_snap_int_nxt  = in_integer_current_assignment;
          w_snap_bool_nxt = in_boolean_current_assignment;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EVAL: begin
        // r_gain_en is high exactly when the current candidate is valid
        if (r_gain_en) begin
          if (r_cnt == LP_LAST_CNT) begin
            w_sample  = 1'b1;
            w_cnt_nxt = '0;
            if ((in_number_of_satisfied_clauses == LP_GAIN_FULL) || (r_idx == LP_LAST_IDX)) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_idx_nxt = r_idx + LP_IDX_ONE;
            end
          end else begin
            w_cnt_nxt = r_cnt + LP_CNT_ONE;
          end
        end else begin
          // Invalid candidate: spend one cycle and move on
          if (r_idx == LP_LAST_IDX) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt = r_idx + LP_IDX_ONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Candidate 0 always wins so the result defaults to "no move"; ties keep the lower index
  assign w_update = w_sample &&
                    ((r_idx == '0) || (in_number_of_satisfied_clauses > r_best_gain));

  // FSM state, index, latency counter and snapshot registers
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_snap_int  <= '0;
      r_snap_bool <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_snap_int  <= w_snap_int_nxt;
      r_snap_bool <= w_snap_bool_nxt;
    end
  end

  // Candidate outputs towards the gain stage; invalid candidates are never loaded
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_after_int  <= '0;
      r_after_bool <= '0;
      r_gain_en    <= 1'b0;
    end else begin
      r_gain_en <= (w_state_nxt == ST_EVAL) && w_cand_valid;
      if ((w_state_nxt == ST_EVAL) && w_cand_valid) begin
        r_after_int  <= w_cand_int;
        r_after_bool <= w_cand_bool;
      end else begin
        r_after_int  <= r_after_int;
        r_after_bool <= r_after_bool;
      end
    end
  end

  // Best-so-far registers: cleared to the snapshot on start, updated on a winning sample
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_best_int  <= '0;
      r_best_bool <= '0;
      r_best_gain <= '0;
      r_best_idx  <= '0;
    end else if (w_start) begin
      r_best_int  <= in_integer_current_assignment;
      r_best_bool <= in_boolean_current_assignment;
      r_best_gain <= '0;
      r_best_idx  <= '0;
    end else if (w_update) begin
      // The presented candidate is the one whose gain is being sampled
      r_best_int  <= r_after_int;
      r_best_bool <= r_after_bool;
      r_best_gain <= in_number_of_satisfied_clauses;
      r_best_idx  <= r_idx;
    end else begin
      r_best_int  <= r_best_int;
      r_best_bool <= r_best_bool;
      r_best_gain <= r_best_gain;
      r_best_idx  <= r_best_idx;
    end
  end

  // Status flags: busy spans the search, done pulses once as the FSM leaves DONE
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (r_state == ST_DONE);
    end
  end

  assign out_integer_assignment_after_move = r_after_int;
  assign out_boolean_assignment_after_move = r_after_bool;
  assign out_gain_enable                   = r_gain_en;
  assign out_best_integer_assignment       = r_best_int;
  assign out_best_boolean_assignment       = r_best_bool;
  assign out_best_gain                     = r_best_gain;
  assign out_best_move_index               = r_best_idx;
  assign out_busy                          = r_busy;
  assign out_done                          = r_done;

endmodule : local_search_move_selector

// File: tb/tb_local_search_move_selector.sv
// -----------------------------------------------------------------------------
// tb_local_search_move_selector
// Directed, table-driven bench. A behavioural gain stage (one register, giving
// a two-cycle latency from a stable candidate to a valid gain) identifies the
// presented candidate from its own list built from the snapshot and returns
// the gain from a per-candidate table.
// -----------------------------------------------------------------------------
module tb_local_search_move_selector;

  localparam int W  = 4;
  localparam int NI = 2;
  localparam int NB = 2;
  localparam int NC = 7;
  localparam int IW = 3;
  localparam int GW = 3;

  logic              in_clk = 1'b0;
  logic              in_reset = 1'b0;
  logic              in_start = 1'b0;
  logic [NI*W-1:0]   in_int = '0;
  logic [NB-1:0]     in_bool = '0;
  logic [GW-1:0]     in_gain;
  logic [NI*W-1:0]   out_int;
  logic [NB-1:0]     out_bool;
  logic              out_gain_enable;
  logic [NI*W-1:0]   out_best_int;
  logic [NB-1:0]     out_best_bool;
  logic [GW-1:0]     out_best_gain;
  logic [IW-1:0]     out_best_idx;
  logic              out_busy;
  logic              out_done;

  local_search_move_selector dut (
    .in_clk                            (in_clk),
    .in_reset                          (in_reset),
    .in_start                          (in_start),
    .in_integer_current_assignment     (in_int),
    .in_boolean_current_assignment     (in_bool),
    .in_number_of_satisfied_clauses    (in_gain),
    .out_integer_assignment_after_move (out_int),
    .out_boolean_assignment_after_move (out_bool),
    .out_gain_enable                   (out_gain_enable),
    .out_best_integer_assignment       (out_best_int),
    .out_best_boolean_assignment       (out_best_bool),
    .out_best_gain                     (out_best_gain),
    .out_best_move_index               (out_best_idx),
    .out_busy                          (out_busy),
    .out_done                          (out_done)
  );

  always #5 in_clk = ~in_clk;

  int checks = 0;
  int errors = 0;

  // Gain-stage model state: snapshot of the search in flight and its gain table
  logic signed [W-1:0] m_int0 = '0;
  logic signed [W-1:0] m_int1 = '0;
  logic [NB-1:0]       m_bool = '0;
  logic [GW-1:0]       m_tab [NC];
  logic [GW-1:0]       g_pipe;

  typedef struct {
    int               i0;
    int               i1;
    int               b;
    logic [6:0][2:0]  tab;
    int               exp_idx;
    int               exp_gain;
    int               e0;
    int               e1;
    int               eb;
    int               lat;
    int               mask;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [6:0][2:0] tab7(input int g0, g1, g2, g3, g4, g5, g6);
    logic [6:0][2:0] t;
    t[0] = 3'(g0); t[1] = 3'(g1); t[2] = 3'(g2); t[3] = 3'(g3);
    t[4] = 3'(g4); t[5] = 3'(g5); t[6] = 3'(g6);
    return t;
  endfunction

  // Bench-side candidate list: 0 none, 1/2 int0 +1/-1, 3/4 int1 +1/-1, 5/6 bool flips
  function automatic bit model_cand(input int c, output logic [NI*W-1:0] ai, output logic [NB-1:0] ab);
    logic signed [W-1:0] a0;
    logic signed [W-1:0] a1;
    bit ok;
    a0 = m_int0; a1 = m_int1; ab = m_bool; ok = 1'b1;
    case (c)
      0: ok = 1'b1;
      1: if (m_int0 == 4'sd7)     ok = 1'b0; else a0 = m_int0 + 4'sd1;
      2: if (m_int0 == 4'sb1000)  ok = 1'b0; else a0 = m_int0 - 4'sd1;
      3: if (m_int1 == 4'sd7)     ok = 1'b0; else a1 = m_int1 + 4'sd1;
      4: if (m_int1 == 4'sb1000)  ok = 1'b0; else a1 = m_int1 - 4'sd1;
      5: ab[0] = ~m_bool[0];
      6: ab[1] = ~m_bool[1];
      default: ok = 1'b0;
    endcase
    ai = {a1, a0};
    return ok;
  endfunction

  function automatic int lookup(input logic [NI*W-1:0] ai, input logic [NB-1:0] ab);
    logic [NI*W-1:0] ci;
    logic [NB-1:0]   cb;
    for (int c = 0; c < NC; c++) begin
      if (model_cand(c, ci, cb) && (ci == ai) && (cb == ab)) return c;
    end
    return -1;
  endfunction

  // Behavioural gain stage: one pipeline register, zero when not enabled
  always @(posedge in_clk or negedge in_reset) begin
    int li;
    if (!in_reset) begin
      g_pipe <= '0;
    end else begin
      li = lookup(out_int, out_bool);
      if (out_gain_enable && (li >= 0)) g_pipe <= m_tab[li];
      else                              g_pipe <= '0;
    end
  end
  assign in_gain = g_pipe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_model(input vec_t v);
    m_int0 = 4'(v.i0);
    m_int1 = 4'(v.i1);
    m_bool = 2'(v.b);
    for (int c = 0; c < NC; c++) m_tab[c] = v.tab[c];
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({out_int, out_bool, out_gain_enable, out_best_int, out_best_bool,
                out_best_gain, out_best_idx, out_busy, out_done});
  endfunction

  // One complete search from a table entry, with latency and coverage of presented candidates
  task automatic run_search(input vec_t v, input string tag);
    int          n;
    int          li;
    bit          got;
    bit          bad;
    logic [6:0]  seen;
    @(negedge in_clk);
    load_model(v);
    in_int   = {4'(v.i1), 4'(v.i0)};
    in_bool  = 2'(v.b);
    in_start = 1'b1;
    @(posedge in_clk);
    #1;
    in_start = 1'b0;
    // Snapshot inputs wander while busy; the result must not depend on them
    in_int  = ~in_int;
    in_bool = ~in_bool;
    n = 0; got = 1'b0; bad = 1'b0; seen = '0;
    while (!got && (n < 100)) begin
      if (out_gain_enable) begin
        li = lookup(out_int, out_bool);
        if (li >= 0) seen[li] = 1'b1;
        else         bad = 1'b1;
      end
      @(posedge in_clk);
      #1;
      n++;
      if (out_done) got = 1'b1;
    end
    chk({tag, " done"},       32'(got), 32'd1);
    chk({tag, " latency"},    32'(n), 32'(v.lat));
    chk({tag, " best_idx"},   32'(out_best_idx), 32'(v.exp_idx));
    chk({tag, " best_gain"},  32'(out_best_gain), 32'(v.exp_gain));
    chk({tag, " best_int"},   32'(out_best_int), 32'({4'(v.e1), 4'(v.e0)}));
    chk({tag, " best_bool"},  32'(out_best_bool), 32'(v.eb));
    chk({tag, " driven"},     32'(seen), 32'(v.mask));
    chk({tag, " bad_cand"},   32'(bad), 32'd0);
    chk({tag, " en_at_done"}, 32'(out_gain_enable), 32'd0);
    chk({tag, " busy_done"},  32'(out_busy), 32'd0);
    @(posedge in_clk);
    #1;
    chk({tag, " done_pulse"}, 32'(out_done), 32'd0);
  endtask

  initial begin
    int pulses;
    int busy_seen;
    int second_at;

    //            i0  i1 b  gain table                  idx gain e0  e1 eb lat mask
    vecs[0] = '{-2,  3, 1, tab7(1,2,3,2,1,2,1),  2,  3,  -3,  3, 1, 15, 'h7f}; // basic
    vecs[1] = '{-2,  3, 1, tab7(2,2,2,2,2,2,2),  0,  2,  -2,  3, 1, 15, 'h7f}; // tie
    vecs[2] = '{ 7, -8, 1, tab7(1,2,3,2,1,2,1),  2,  3,   6, -8, 1, 13, 'h6d}; // saturation, skips 1,4
    vecs[3] = '{-2,  3, 1, tab7(1,2,3,4,1,2,1),  3,  4,  -2,  4, 1,  9, 'h0f}; // early exit at 3
    vecs[4] = '{ 0,  0, 0, tab7(0,1,1,1,1,1,3),  6,  3,   0,  0, 2, 15, 'h7f}; // boolean winner
    vecs[5] = '{-2,  3, 1, tab7(4,0,0,0,0,0,0),  0,  4,  -2,  3, 1,  3, 'h01}; // early exit at 0
    vecs[6] = '{-8,  7, 2, tab7(0,0,0,0,0,0,0),  0,  0,  -8,  7, 2, 13, 'h73}; // saturation, skips 2,3

    // Reset state
    repeat (2) @(negedge in_clk);
    chk("reset_outputs", all_outputs(), 32'd0);
    in_reset = 1'b1;
    @(negedge in_clk);
    chk("idle_outputs", all_outputs(), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_search(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of an evaluation aborts without a done pulse
    @(negedge in_clk);
    load_model(vecs[0]);
    in_int   = {4'(vecs[0].i1), 4'(vecs[0].i0)};
    in_bool  = 2'(vecs[0].b);
    in_start = 1'b1;
    @(posedge in_clk);
    #1;
    in_start = 1'b0;
    chk("abort_busy_before", 32'(out_busy), 32'd1);
    repeat (5) @(posedge in_clk);
    #1;
    in_reset = 1'b0;
    #1;
    chk("abort_outputs", all_outputs(), 32'd0);
    @(negedge in_clk);
    in_reset = 1'b1;
    pulses = 0; busy_seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge in_clk);
      #1;
      if (out_done) pulses++;
      if (out_busy) busy_seen++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    chk("abort_idle", 32'(busy_seen), 32'd0);
    run_search(vecs[0], "after_abort");

    // Start held high: one done per search, back-to-back restart latches the new snapshot
    @(negedge in_clk);
    load_model(vecs[0]);
    in_int   = {4'(vecs[0].i1), 4'(vecs[0].i0)};
    in_bool  = 2'(vecs[0].b);
    in_start = 1'b1;
    pulses = 0; second_at = -1;
    for (int n = 0; n < 45; n++) begin
      @(posedge in_clk);
      #1;
      if (n == 0) begin
        in_int  = {4'(vecs[4].i1), 4'(vecs[4].i0)};
        in_bool = 2'(vecs[4].b);
      end
      if (out_done) begin
        pulses++;
        if (pulses == 1) begin
          chk("held_first_at",   32'(n), 32'd15);
          chk("held_first_idx",  32'(out_best_idx), 32'd2);
          chk("held_first_int",  32'(out_best_int), 32'({4'sd3, -4'sd3}));
          load_model(vecs[4]);
        end else if (pulses == 2) begin
          second_at = n;
          chk("held_second_idx",  32'(out_best_idx), 32'd6);
          chk("held_second_bool", 32'(out_best_bool), 32'd2);
          chk("held_second_int",  32'(out_best_int), 32'd0);
          in_start = 1'b0;
        end else begin
          in_start = 1'b0;
        end
      end
    end
    in_start = 1'b0;
    chk("held_second_at", 32'(second_at), 32'd31);
    chk("held_pulses",    32'(pulses), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_local_search_move_selector
